data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter that shares the single-port synchronous data RAM between the `micro` core (port 0) and a host/debug requester (port 1). It serialises accesses through a three-state sequencer, registers all RAM-side signals, and returns read data with a one-cycle completion pulse. By default it arbitrates round-robin. It sits between the requesters and the data RAM in the top level.

## Interface
- `ADDR_W`, default 8: RAM address width.
- `DATA_W`, default 8: RAM data width.
- `_iClk` in 1: sole clock, all logic on rising edge.
- `_iReset_n` in 1: asynchronous, active-low reset. Deassertion is synchronised to `_iClk` at top level.
- `_iReq[1:0]` in 2: per-port access request, level.
- `_iWrite[1:0]` in 2: per-port 1 = write, 0 = read. Sampled with the request.
- `_iAddr0`, `_iAddr1` in ADDR_W: per-port address.
- `_iWData0`, `_iWData1` in DATA_W: per-port write data.
- `_oGnt[1:0]` out 2: one-cycle grant pulse, one-hot.
- `_oDone[1:0]` out 2: one-cycle completion pulse, for both reads and writes.
- `_oRData` out DATA_W: read data, valid while the matching `_oDone` is high. Holds its value otherwise.
- `_oMemAddr` out ADDR_W: RAM address, registered.
- `_oMemWData` out DATA_W: RAM write data, registered.
- `_oMemWrite` out 1: RAM write strobe, registered, one cycle.
- `_iMemRData` in DATA_W: RAM read data, available the cycle after the address is presented.

## Operation
- States are `ARB_IDLE`, `ARB_ISSUE` and `ARB_WAIT`. There is no other state.
- **`ARB_IDLE`**
  - With no request: stay in `ARB_IDLE`.
  - With a request: select a winner and register its address and write data onto the RAM outputs.
  - If the winner is writing, set `_oMemWrite` = 1.
  - Pulse `_oGnt[winner]`, record `last` = winner, and go to `ARB_ISSUE`.
- **`ARB_ISSUE`**
  - Clear `_oMemWrite`. The RAM performs the write, or registers the read, at this edge.
  - Go to `ARB_WAIT`.
- **`ARB_WAIT`**
  - For a read, capture `_iMemRData` into `_oRData`. For a write, leave `_oRData` unchanged.
  - Pulse `_oDone[last]` and go to `ARB_IDLE`.
- **Winner selection**
  - Only one port requesting: that port wins.
  - Both ports requesting: the port that is not `last` wins.
- **Requester rules**
  - Hold `_iReq`, `_iWrite`, `_iAddrN` and `_iWDataN` stable until `_oGnt` is seen.
  - Drop `_iReq` in the cycle after the grant. A request still high in `ARB_IDLE` is treated as a new access.
  - Requests arriving in `ARB_ISSUE` or `ARB_WAIT` are held pending. They are not lost as long as the requester keeps `_iReq` high.
- **Widths:** addresses and data pass through unmodified. There is no arithmetic apart from the one-bit `last` toggle.

## Timing
- **Reset values:**
  - `_oGnt` = 0, `_oDone` = 0, `_oRData` = 0.
  - `_oMemAddr` = 0, `_oMemWData` = 0, `_oMemWrite` = 0.
  - State = `ARB_IDLE`, `last` = 1, so port 0 wins the first contention.
- **Cycle-level access timing:**
  - Request sampled in cycle N.
  - `_oGnt` and the RAM outputs are valid in cycle N+1.
  - RAM data appears in cycle N+2.
  - `_oDone` and `_oRData` are valid in cycle N+3, when the arbiter is back in `ARB_IDLE`.
- **Throughput:** one access every 3 cycles. A new request can be sampled in the same cycle that `_oDone` is high.
- **Simultaneous requests:** exactly one grant per access. The two ports alternate while both keep requesting.
- **Reset mid-operation:** all outputs clear immediately. An in-flight read is abandoned with no `_oDone`. A write in `ARB_IDLE`→`ARB_ISSUE` whose strobe is cleared before the edge does not reach RAM.

## Configuration
- **`MEM_ARB_FIXED_PRIO_EN` defined:** fixed priority. Port 0 always wins contention and `last` is ignored for selection, though still used to route `_oDone`.
- **`MEM_ARB_FIXED_PRIO_EN` undefined (default):** round-robin as described under Operation.

## Structure
- `cpu_pkg` gains:
  - the `ArbState` enum (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, 2 bits);
  - `MEM_ARB_PORTS` = 2.
- Sub-module `rr_select`:
  - purely combinational;
  - inputs are `_iReq[1:0]` and `last`;
  - output is the one-hot winner;
  - holds the `MEM_ARB_FIXED_PRIO_EN` switch.
- The top level contains the FSM, registered RAM outputs and response path.

## Test plan
- Reset, then port 0 reads 0x10 with RAM preloaded 0xA5 → `_oGnt` = 01 at N+1, `_oMemAddr` = 0x10, `_oDone` = 01 and `_oRData` = 0xA5 at N+3.
- Port 1 writes 0x3C to 0x20, then port 0 reads 0x20 → one `_oMemWrite` pulse with addr 0x20 / data 0x3C, and the read returns 0x3C.
- Both ports request reads continuously from reset → grants alternate 01, 10, 01, 10 at 3-cycle spacing. With `MEM_ARB_FIXED_PRIO_EN`, grants are always 01.
- Port 1 raises `_iReq` during port 0's `ARB_ISSUE` → port 1 is granted at N+4, immediately after port 0's `_oDone`, with no lost request.
- Assert `_iReset_n` low during `ARB_ISSUE` of a read → all outputs are 0 asynchronously, no `_oDone`, and the next request after release is granted to port 0.
- A write completes → `_oDone` pulses and `_oRData` keeps its previous read value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: data-RAM arbiter state encoding and port count.
package cpu_pkg;

  localparam int MEM_ARB_PORTS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } ArbState;

endpackage

// File: rtl/data_mem_arbiter_rr_select.sv
// Winner selection for the data-RAM arbiter (combinational, one-hot result).
// Build option: MEM_ARB_FIXED_PRIO_EN -> port 0 always wins contention;
// otherwise the port that did not win last time wins.
module rr_select
  import cpu_pkg::*;
(
  input  logic [MEM_ARB_PORTS-1:0] _iReq,
  input  logic                     last,
  output logic [MEM_ARB_PORTS-1:0] win
);

  // A lone requester always wins; contention resolved by priority policy.
  always_comb begin
    win = _iReq;
    if (&_iReq) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win = 2'b01;
`else
      win = last ? 2'b01 : 2'b10;
`endif
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data RAM.
// Each access runs IDLE -> ISSUE -> WAIT; RAM-side signals are registered and
// read data returns with a one-cycle done pulse three cycles after sampling.
// Build option: MEM_ARB_FIXED_PRIO_EN (see rr_select).
module data_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                     _iClk,
  input  logic                     _iReset_n,
  input  logic [MEM_ARB_PORTS-1:0] _iReq,
  input  logic [MEM_ARB_PORTS-1:0] _iWrite,
  input  logic [ADDR_W-1:0]        _iAddr0,
  input  logic [ADDR_W-1:0]        _iAddr1,
  input  logic [DATA_W-1:0]        _iWData0,
  input  logic [DATA_W-1:0]        _iWData1,
  output logic [MEM_ARB_PORTS-1:0] _oGnt,
  output logic [MEM_ARB_PORTS-1:0] _oDone,
  output logic [DATA_W-1:0]        _oRData,
  output logic [ADDR_W-1:0]        _oMemAddr,
  output logic [DATA_W-1:0]        _oMemWData,
  output logic                     _oMemWrite,
  input  logic [DATA_W-1:0]        _iMemRData
);

  ArbState                                state;
  logic                                   last;
  logic                                   curWrite;
  logic [MEM_ARB_PORTS-1:0]               win;
  logic [MEM_ARB_PORTS-1:0][ADDR_W-1:0]   addrs;
  logic [MEM_ARB_PORTS-1:0][DATA_W-1:0]   wdatas;

  assign addrs  = {_iAddr1, _iAddr0};
  assign wdatas = {_iWData1, _iWData0};

  rr_select uSel (
    ._iReq (_iReq),
    .last  (last),
    .win   (win)
  );

  // Access sequencer: grant + RAM drive, strobe clear, then response capture.
  always_ff @(posedge _iClk or negedge _iReset_n) begin
    if (!_iReset_n) begin
      state      <= ARB_IDLE;
      last       <= 1'b1;
      curWrite   <= 1'b0;
      _oGnt      <= '0;
      _oDone     <= '0;
      _oRData    <= '0;
      _oMemAddr  <= '0;
      _oMemWData <= '0;
      _oMemWrite <= 1'b0;
    end else begin
      _oGnt  <= '0;
      _oDone <= '0;
      case (state)
        ARB_IDLE: begin
          if (|_iReq) begin
            _oMemAddr  <= addrs[win[1]];
            _oMemWData <= wdatas[win[1]];
            _oMemWrite <= |(_iWrite & win);
            curWrite   <= |(_iWrite & win);
            _oGnt      <= win;
            last       <= win[1];
            state      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          _oMemWrite <= 1'b0;
          state      <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // Writes leave the last read value visible.
          if (!curWrite) _oRData <= _iMemRData;
          _oDone[last] <= 1'b1;
          state        <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios followed by random
// two-port traffic checked against a transaction-level model.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0, wr = '0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, done;
  logic [7:0] rData, memAddr, memWData, memRData;
  logic       memWrite;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    ._iClk(clk), ._iReset_n(rst_n), ._iReq(req), ._iWrite(wr),
    ._iAddr0(addr0), ._iAddr1(addr1), ._iWData0(wdata0), ._iWData1(wdata1),
    ._oGnt(gnt), ._oDone(done), ._oRData(rData), ._oMemAddr(memAddr),
    ._oMemWData(memWData), ._oMemWrite(memWrite), ._iMemRData(memRData)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on strobe, read data one cycle after the address.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (memWrite) ram[memAddr] <= memWData;
    memRData <= ram[memAddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit v; bit wr; logic [7:0] a; logic [7:0] d; } req_t;
  typedef struct { int port; bit wr; logic [7:0] a; logic [7:0] d; logic [7:0] rd; int cyc; } exp_t;

  req_t       pend [2];
  exp_t       gntQ [$];
  exp_t       doneQ [$];
  logic [7:0] refMem [256];
  bit         mLast = 1'b1;
  logic [7:0] mRd = '0;
  logic [7:0] heldRd = '0;
  bit         monOn = 1'b0;
  int         nAssert = 0, nFail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or done.
  always @(negedge clk) begin
    exp_t e;
    if (monOn && rst_n) begin
      if (gnt != 2'b00) begin
        if (gntQ.size() == 0) chk("gnt_unexpected", {30'd0, gnt}, 0);
        else begin
          e = gntQ.pop_front();
          chk("gnt_onehot", {30'd0, gnt}, 32'(1) << e.port);
          chk("gnt_cycle", cyc, e.cyc + 1);
          chk("mem_addr", {24'd0, memAddr}, {24'd0, e.a});
          if (e.wr) chk("mem_wdata", {24'd0, memWData}, {24'd0, e.d});
          chk("mem_write", {31'd0, memWrite}, {31'd0, e.wr});
        end
      end else if (memWrite) chk("mem_write_stray", 1, 0);
      if (done != 2'b00) begin
        if (doneQ.size() == 0) chk("done_unexpected", {30'd0, done}, 0);
        else begin
          e = doneQ.pop_front();
          chk("done_onehot", {30'd0, done}, 32'(1) << e.port);
          chk("done_cycle", cyc, e.cyc + 3);
          chk(e.wr ? "rdata_after_write" : "rdata", {24'd0, rData}, {24'd0, e.rd});
          heldRd = e.rd;
        end
      end else if (rData !== heldRd) chk("rdata_hold", {24'd0, rData}, {24'd0, heldRd});
    end
  end

  task automatic drive();
    req    = {pend[1].v, pend[0].v};
    wr     = {pend[1].wr, pend[0].wr};
    addr0  = pend[0].a;  addr1  = pend[1].a;
    wdata0 = pend[0].d;  wdata1 = pend[1].d;
  endtask

  function automatic req_t rndReq();
    req_t r;
    r.v = 1'b1; r.wr = 1'($urandom_range(0, 1));
    r.a = 8'($urandom_range(0, 15)); r.d = 8'($urandom);
    return r;
  endfunction

  // One arbitration slot starting at a negedge with the DUT idle.
  // late: the loser slot gets a fresh request while the winner is in ISSUE.
  task automatic step(input bit late);
    int w; exp_t e;
    drive();
    if (!pend[0].v && !pend[1].v) begin @(negedge clk); return; end
    if (pend[0].v && pend[1].v) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = mLast ? 0 : 1;
`endif
    end else w = pend[0].v ? 0 : 1;
    mLast = (w == 1);
    e.port = w; e.wr = pend[w].wr; e.a = pend[w].a; e.d = pend[w].d; e.cyc = cyc;
    if (e.wr) refMem[e.a] = e.d;
    else mRd = refMem[e.a];
    e.rd = mRd;
    gntQ.push_back(e); doneQ.push_back(e);
    @(negedge clk);
    pend[w].v = 1'b0;
    if (late && !pend[1-w].v) pend[1-w] = rndReq();
    drive();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic setReq(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    pend[p].v = 1'b1; pend[p].wr = w; pend[p].a = a; pend[p].d = d;
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      refMem[i] = 8'($urandom);
      ram[i]    = refMem[i];
    end
    refMem[8'h10] = 8'hA5; ram[8'h10] = 8'hA5;
    pend[0] = '{0, 0, 0, 0}; pend[1] = '{0, 0, 0, 0};
    drive();
    #23;
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_done", {30'd0, done}, 0);
    chk("rst_rdata", {24'd0, rData}, 0);
    chk("rst_mem_addr", {24'd0, memAddr}, 0);
    chk("rst_mem_wdata", {24'd0, memWData}, 0);
    chk("rst_mem_write", {31'd0, memWrite}, 0);
    @(negedge clk); rst_n = 1'b1; monOn = 1'b1;
    @(negedge clk);

    // Read of preloaded location, then write by port 1 and read-back by port 0.
    setReq(0, 0, 8'h10, 8'h00); step(0);
    setReq(1, 1, 8'h20, 8'h3C); step(0);
    setReq(0, 0, 8'h20, 8'h00); step(0);
    // Write completion must leave read data untouched.
    setReq(1, 1, 8'h21, 8'h77); step(0);

    // Both ports continuously requesting reads.
    setReq(0, 0, 8'h01, 0); setReq(1, 0, 8'h02, 0);
    for (int k = 0; k < 6; k++) begin
      step(0);
      if (!pend[0].v) setReq(0, 0, 8'($urandom_range(0, 15)), 0);
      if (!pend[1].v) setReq(1, 0, 8'($urandom_range(0, 15)), 0);
    end
    pend[0].v = 0; pend[1].v = 0;
    step(0); step(0);  // drain

    // Port 1 raises its request while port 0 is in ISSUE.
    setReq(0, 0, 8'h05, 0); step(1); step(0);

    // Reset during ISSUE of a read: outputs clear, no done.
    setReq(0, 0, 8'h10, 0); drive();
    e.port = 0; e.wr = 0; e.a = 8'h10; e.d = 0; e.rd = refMem[8'h10]; e.cyc = cyc;
    gntQ.push_back(e);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_gnt", {30'd0, gnt}, 0);
    chk("mid_rst_done", {30'd0, done}, 0);
    chk("mid_rst_rdata", {24'd0, rData}, 0);
    chk("mid_rst_mem_addr", {24'd0, memAddr}, 0);
    chk("mid_rst_mem_write", {31'd0, memWrite}, 0);
    gntQ.delete(); doneQ.delete();
    mLast = 1'b1; mRd = '0; heldRd = '0;
    pend[0].v = 0; pend[1].v = 0; drive();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    setReq(0, 0, 8'h03, 0); setReq(1, 0, 8'h04, 0);
    step(0); step(0);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 1) == 1) pend[p] = rndReq();
      step($urandom_range(0, 2) == 0);
    end
    pend[0].v = 0; pend[1].v = 0;
    step(0); step(0);
    repeat (4) @(negedge clk);
    chk("gnt_queue_empty", gntQ.size(), 0);
    chk("done_queue_empty", doneQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
